// File: rtl/fetch_queue_pkg.sv
// Shared CPU constants and the fetch-queue entry layout.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_queue_pkg;

  // Architectural reset PC, shared with the PC register.
  localparam logic [31:0] CPU_RESET_PC  = 32'h0000_3000;
  // Encoding used as a bubble when nothing is queued.
  localparam logic [31:0] CPU_NOP_INSTR = 32'h0000_0000;

  // One queued fetch: PC in the upper half, instruction in the lower half.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_storage.sv
// fq_storage: DEPTH x 64-bit register array, one write port, one async read port.
// Latency: write lands on the posedge; read is combinational from rd_addr.
// Backpressure: none; the controller only writes when a push is legal.
module fq_storage #(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [63:0]   wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [63:0]   rd_data
);

  logic [63:0] mem [DEPTH];

  // Contents are never cleared; validity is owned by the pointers in the controller.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: FIFO of fetched {pc, instr} between fetch and decode.
// Latency: one cycle from push edge to visibility on out_*; no bypass.
// Backpressure: in_ready = not full (registered only), doubles as fetch PC-hold.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = CPU_RESET_PC
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_instr,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          push;
  logic          pop;
  fq_entry_t     wr_entry;
  fq_entry_t     rd_entry;

  // Flags come only from the registered count, so out_ready never reaches in_ready.
  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign count     = count_q;

  // A full queue refuses the offer even if the head drains this same cycle.
  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  assign wr_entry = '{pc: in_pc, instr: in_instr};

  // Pointer and occupancy control; reset outranks flush, flush outranks push/pop.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  fq_storage #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_storage (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr),
    .rd_data (rd_entry)
  );

  // Empty queue presents the reset PC with a nop so decode sees a harmless bubble.
  always_comb begin
    out_pc    = RESET_PC;
    out_instr = CPU_NOP_INSTR;
    if (out_valid) begin
      out_pc    = rd_entry.pc;
      out_instr = rd_entry.instr;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: accepted pushes go into a scoreboard queue,
// a negedge monitor pops and compares whenever the DUT hands an entry to decode.
// State checks (count/flags/empty outputs) use hand-computed constants.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_pc = 32'h0;
  logic [31:0] in_instr = 32'h0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q [$];

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_3000)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .count     (count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {pc[15:0] ^ 16'h5A5A, 16'hBEEF};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs (from posedge+1), let the edge pass, return at posedge+1.
  // acc: whether the hand analysis says this offer is accepted at the coming edge.
  task automatic cyc(input logic iv, input logic [31:0] pc, input logic ordy,
                     input logic fl, input logic rs, input logic acc);
    in_valid  = iv;
    in_pc     = pc;
    in_instr  = instr_of(pc);
    out_ready = ordy;
    flush     = fl;
    reset     = rs;
    if (fl || rs) exp_q.delete();
    if (acc) exp_q.push_back({pc, instr_of(pc)});
    @(posedge clk);
    #1;
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, ".count"},     32'(count),     32'd0);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".in_ready"},  32'(in_ready),  32'd1);
    chk({tag, ".out_pc"},    out_pc,         32'h0000_3000);
    chk({tag, ".out_instr"}, out_instr,      32'h0000_0000);
  endtask

  // Scoreboard monitor: a handshake seen at negedge is consumed at the next posedge.
  always @(negedge clk) begin
    if (!reset && !flush && out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL mon.unexpected: got pc %h expected no entry", out_pc);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if (out_pc !== e[63:32] || out_instr !== e[31:0]) begin
          bad++;
          $display("FAIL mon.head: got %h/%h expected %h/%h", out_pc, out_instr, e[63:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held for two cycles
    cyc(0, 32'h0, 0, 0, 1, 0);
    cyc(0, 32'h0, 0, 0, 1, 0);
    chk_empty("reset");

    // Fill to full with no consumer
    for (int i = 0; i < 4; i++) cyc(1, 32'h3000 + 32'(4*i), 0, 0, 0, 1);
    chk("fill.count",    32'(count),    32'd4);
    chk("fill.in_ready", 32'(in_ready), 32'd0);
    chk("fill.out_pc",   out_pc,        32'h3000);
    // Drain in order (monitor checks 0x3000..0x300C)
    for (int i = 0; i < 4; i++) cyc(0, 32'h0, 1, 0, 0, 0);
    chk_empty("drain");

    // Full with simultaneous offer and pop: offer refused, taken next cycle
    for (int i = 0; i < 4; i++) cyc(1, 32'h3000 + 32'(4*i), 0, 0, 0, 1);
    cyc(1, 32'h3010, 1, 0, 0, 0);
    chk("full_pp.count1", 32'(count), 32'd3);
    cyc(1, 32'h3010, 0, 0, 0, 1);
    chk("full_pp.count2", 32'(count), 32'd4);
    chk("full_pp.head",   out_pc,     32'h3004);
    for (int i = 0; i < 4; i++) cyc(0, 32'h0, 1, 0, 0, 0);
    chk("full_pp.drained", 32'(count), 32'd0);

    // Steady streaming at count=1 for 20 cycles, pointers wrap repeatedly
    cyc(1, 32'h3200, 0, 0, 0, 1);
    chk("stream.start", 32'(count), 32'd1);
    for (int i = 0; i < 20; i++) begin
      cyc(1, 32'h3204 + 32'(4*i), 1, 0, 0, 1);
      chk("stream.count", 32'(count), 32'd1);
      chk("stream.head",  out_pc,     32'h3204 + 32'(4*i));
    end
    cyc(0, 32'h0, 1, 0, 0, 0);
    chk("stream.end", 32'(count), 32'd0);

    // Flush with a coincident offer at count=3
    for (int i = 0; i < 3; i++) cyc(1, 32'h3020 + 32'(4*i), 0, 0, 0, 1);
    chk("flush.pre", 32'(count), 32'd3);
    cyc(1, 32'h3040, 0, 1, 0, 0);
    chk_empty("flush");
    cyc(1, 32'h3100, 0, 0, 0, 1);
    chk("flush.next_pc",    out_pc,        32'h3100);
    chk("flush.next_valid", 32'(out_valid), 32'd1);
    cyc(0, 32'h0, 1, 0, 0, 0);

    // Reset coincident with flush and push at count=2
    cyc(1, 32'h3300, 0, 0, 0, 1);
    cyc(1, 32'h3304, 0, 0, 0, 1);
    chk("rst_mid.pre", 32'(count), 32'd2);
    cyc(1, 32'h3308, 1, 1, 1, 0);
    chk_empty("rst_mid");
    cyc(0, 32'h0, 1, 0, 0, 0);
    chk_empty("rst_mid.after");

    chk("scoreboard.left", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning entry count (power of two, 2..16).
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_3000, meaning PC shown on out_pc when empty.
REQ-003 The block SHALL have port clk  input  1  sole clock, all state on posedge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port flush  input  1  discard all held entries (branch/jump redirect).
REQ-006 The block SHALL have port in_valid  input  1  fetch stage offers {in_pc, in_instr}.
REQ-007 The block SHALL have port in_pc  input  32  PC of the offered instruction.
REQ-008 The block SHALL have port in_instr  input  32  instruction word read from instruction memory.
REQ-009 The block SHALL have port in_ready  output  1  queue accepts an entry this cycle; also the PC-hold (stall) signal to fetch when low.
REQ-010 The block SHALL have port out_valid  output  1  head entry presented to decode.
REQ-011 The block SHALL have port out_ready  input  1  decode consumes head this cycle.
REQ-012 The block SHALL have port out_pc  output  32  PC of head entry.
REQ-013 The block SHALL have port out_instr  output  32  instruction of head entry.
REQ-014 The block SHALL have port count  output  $clog2(DEPTH)+1  number of held entries.

Function
REQ-015 Push SHALL occur on a posedge iff in_valid && in_ready && !flush; pop iff out_valid && out_ready && !flush.
REQ-016 in_ready SHALL equal (count != DEPTH), derived from registered state only, with no combinational path from out_ready.
REQ-017 out_valid SHALL equal (count != 0), derived from registered state only.
REQ-018 Latency SHALL be one cycle: an entry pushed at edge N is visible on out_* after edge N; there is no same-cycle bypass from in_* to out_*.
REQ-019 When empty, out_pc SHALL be RESET_PC and out_instr SHALL be 32'h0000_0000 (nop).
REQ-020 When non-empty, out_pc/out_instr SHALL be the oldest entry's values, in strict FIFO order.
REQ-021 Simultaneous push and pop SHALL leave count unchanged and advance both pointers; this is legal at any non-empty, non-full count.
REQ-022 When full, in_valid SHALL be ignored even if out_ready pops the same cycle; the offered entry is accepted on the following cycle.
REQ-023 When empty, out_ready SHALL be ignored.
REQ-024 Read and write pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH; count SHALL never exceed DEPTH or go below 0.
REQ-025 flush SHALL take priority over push and pop: on the edge where it is sampled, count becomes 0 and pointers return to 0, and the same-cycle in_valid entry is dropped.
REQ-026 Storage contents SHALL NOT need clearing on flush or reset; only pointers and count define validity.

Reset
REQ-027 reset SHALL take priority over flush, push and pop; after the edge: count=0, pointers=0, out_valid=0, in_ready=1, out_pc=RESET_PC, out_instr=0.
REQ-028 Reset asserted mid-stream SHALL discard all entries; a push coincident with reset SHALL be lost.

Structure
REQ-029 RESET_PC (32'h0000_3000) and NOP_INSTR (32'h0) SHALL live in the shared CPU constants package, also used by the PC register.
REQ-030 One sub-module is natural: fq_storage, a DEPTH x 64-bit register array with one write port and one asynchronous read port; pointer/count control stays in fetch_queue.

Verification
REQ-031 The bench SHALL check reset: reset=1 for 2 cycles -> count=0, out_valid=0, in_ready=1, out_pc=0x3000, out_instr=0.
REQ-032 The bench SHALL check fill then drain: push PCs 0x3000,0x3004,0x3008,0x300C with out_ready=0 -> after 4th edge count=4, in_ready=0; then out_ready=1 -> out_pc 0x3000..0x300C in order, then out_valid=0.
REQ-033 The bench SHALL check full with simultaneous push/pop: at count=4, in_valid=1 with PC 0x3010 and out_ready=1 -> next count=3, 0x3010 not stored; the next cycle accepts it, count=4.
REQ-034 The bench SHALL check steady streaming: in_valid=out_ready=1 for 20 cycles from count=1 -> count stays 1, out_pc increments by 4 each cycle, pointers wrap 5 times without error.
REQ-035 The bench SHALL check flush: count=3 with in_valid=1 (PC 0x3040) and flush=1 -> next count=0, out_valid=0; the next push of 0x3100 appears at out_pc one cycle later.
REQ-036 The bench SHALL check reset during flush and push: reset=flush=in_valid=1 at count=2 -> reset state per REQ-027, no entry retained.
